tag_rx_sched: RTL
=================

Name: tag_rx_sched

Overview:
- Sequencer for the tag receive chain.
- Waits for a sync-correlation peak from the RX peak detector, skips the remaining sync preamble, then opens NLOC_PER_SYNC consecutive capture windows of NSIG samples each.
- For each window it drives the capture trigger, the output mux select and the location index, then re-arms for the next sync.
- Sits between the peak detector / sample strobe and the RX output mux, and mirrors its status onto the front-panel GPIO.

Parameters:
- NSYNC_SKIP, 32768, in_valid samples skipped after a peak before the first window (min 1).
- NSIG, 262144, in_valid samples per capture window (min 1).
- NLOC_PER_SYNC, 3, capture windows per detected sync (min 1).
- TIMEOUT, 1048576, in_valid samples spent in SEARCH without a peak before timeout_err (min 2).
- REG_WIDTH, 12, GPIO width (must be ≥ 3 + LOC_W).
- SYNC_CNT_WIDTH, 16, width of the sync counter.
- LOC_W is derived: max(1, clog2(NLOC_PER_SYNC)).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- run_rx  in  1  enable; low aborts to IDLE
- in_valid  in  1  one sample present this cycle
- peak_stb  in  1  sync-peak strobe from the peak detector
- rx_state  out  2  0=IDLE, 1=SEARCH, 2=SKIP, 3=CAPTURE
- rx_trig  out  1  one-cycle pulse at the start of each capture window
- rx_out_mux  out  1  1 while in CAPTURE; selects baseband capture output
- capture_valid  out  1  in_valid qualified by CAPTURE (combinational)
- loc_idx  out  LOC_W  index of the current window
- sync_count  out  SYNC_CNT_WIDTH  accepted peaks, wraps
- timeout_err  out  1  one-cycle pulse on SEARCH timeout
- fp_gpio_out  out  REG_WIDTH  status mirror
- fp_gpio_ddr  out  REG_WIDTH  constant all-ones (all outputs)

Behaviour:
- Reset values:
  - rx_state=IDLE; rx_trig, rx_out_mux, timeout_err, loc_idx, sync_count, fp_gpio_out = 0.
  - Internal sample counter and timeout counter = 0.
  - fp_gpio_ddr is all ones in and out of reset.
- Counting:
  - All sample counters advance only on cycles with in_valid=1.
  - Idle cycles (in_valid=0) freeze all counters.
- IDLE:
  - run_rx=1 → SEARCH on the next edge; counters cleared.
- run_rx=0 in any non-IDLE state:
  - Next edge → IDLE.
  - rx_out_mux, loc_idx and all counters cleared; any pending rx_trig is suppressed.
  - sync_count is retained.
- SEARCH:
  - peak_stb=1 (independent of in_valid) → SKIP next edge; sync_count+1 modulo 2^SYNC_CNT_WIDTH; sample counter cleared.
  - Otherwise, each in_valid increments the timeout counter.
  - When the timeout counter is at TIMEOUT-1 and in_valid=1: timeout_err pulses for 1 cycle, the counter clears, and the state stays SEARCH.
  - peak_stb and timeout in the same cycle: the peak wins and no timeout_err is issued.
- SKIP:
  - peak_stb is ignored.
  - On the in_valid that completes NSYNC_SKIP samples: next edge → CAPTURE with loc_idx=0, rx_out_mux=1 and rx_trig=1 for exactly that one cycle. Sample counter cleared.
- CAPTURE:
  - peak_stb is ignored.
  - capture_valid = in_valid & (rx_state==CAPTURE), zero latency.
  - On the in_valid that completes NSIG samples:
    - If loc_idx < NLOC_PER_SYNC-1: next edge loc_idx+1 and rx_trig pulses 1 cycle; stay in CAPTURE.
    - Else: next edge → SEARCH, loc_idx=0, rx_out_mux=0, timeout counter cleared.
  - Each window therefore contains exactly NSIG capture_valid cycles, and windows are back-to-back with no dropped sample.
- All outputs are registered except capture_valid. rx_trig is high in the first cycle rx_out_mux/loc_idx show the new window.
- fp_gpio_out, registered one cycle after the state/outputs it reflects:
  - [1:0] = rx_state
  - [2] = rx_trig
  - [3+LOC_W-1:3] = loc_idx
  - upper bits = 0
- Reset mid-operation takes priority over every other event.

Test Plan:
1. Reset, then run_rx=1 with NSYNC_SKIP=8, NSIG=16, NLOC=3, in_valid continuous, one peak_stb.
   - rx_state goes 1→2, then 3 after 8 samples.
   - Three rx_trig pulses spaced 16 cycles apart; loc_idx 0,1,2; 48 capture_valid cycles total.
   - Then rx_state=1 and sync_count=1.
2. Same as scenario 1 but in_valid toggling 1,0,1,0.
   - Every window still has exactly 16 capture_valid cycles.
   - rx_trig spacing is 32 cycles; counts are unaffected by gaps.
3. TIMEOUT=32, continuous in_valid, no peak.
   - timeout_err pulses at SEARCH sample 32 and again at 64; state stays 1.
   - Also assert peak_stb on the cycle of the 32nd sample: transition to SKIP with no timeout_err.
4. Deassert run_rx mid-CAPTURE (loc_idx=1).
   - Next cycle: rx_state=0, rx_out_mux=0, loc_idx=0, no rx_trig.
   - Re-assert run_rx: SEARCH restarts from count 0.
5. Extra peak_stb pulses during SKIP and CAPTURE.
   - Ignored: sync_count unchanged, sequence timing identical to scenario 1.
   - Verify fp_gpio_out equals {0, loc_idx, rx_trig, rx_state} delayed 1 cycle.
   - Verify fp_gpio_ddr = 12'hFFF.
6. Assert reset during SKIP.
   - All outputs return to their reset values on the next edge; sync_count=0.
   - Set sync_count to 2^16-1 and apply one peak: sync_count wraps to 0.

Source files
------------

// File: rtl/tag_rx_sched_if.sv
// Purpose: bundles the control/status signals between tag_rx_sched and its neighbours
//          (peak detector, sample strobe, RX output mux, front-panel GPIO).
// Ports:   slave = scheduler side (samples run_rx/in_valid/peak_stb, drives status);
//          master = environment side (drives run_rx/in_valid/peak_stb, observes status).
interface tag_rx_sched_if #(
    parameter int NLOC_PER_SYNC  = 3,
    parameter int REG_WIDTH      = 12,
    parameter int SYNC_CNT_WIDTH = 16
);
    localparam int LOC_W = (NLOC_PER_SYNC > 1) ? $clog2(NLOC_PER_SYNC) : 1;

    logic                      run_rx;
    logic                      in_valid;
    logic                      peak_stb;
    logic [1:0]                rx_state;
    logic                      rx_trig;
    logic                      rx_out_mux;
    logic                      capture_valid;
    logic [LOC_W-1:0]          loc_idx;
    logic [SYNC_CNT_WIDTH-1:0] sync_count;
    logic                      timeout_err;
    logic [REG_WIDTH-1:0]      fp_gpio_out;
    logic [REG_WIDTH-1:0]      fp_gpio_ddr;

    modport slave (
        input  run_rx, in_valid, peak_stb,
        output rx_state, rx_trig, rx_out_mux, capture_valid, loc_idx,
               sync_count, timeout_err, fp_gpio_out, fp_gpio_ddr
    );

    modport master (
        output run_rx, in_valid, peak_stb,
        input  rx_state, rx_trig, rx_out_mux, capture_valid, loc_idx,
               sync_count, timeout_err, fp_gpio_out, fp_gpio_ddr
    );
endinterface

// File: rtl/tag_rx_sched.sv
// Purpose: tag RX sequencer: SEARCH for a sync peak, SKIP the rest of the preamble,
//          then run NLOC_PER_SYNC back-to-back CAPTURE windows of NSIG samples each.
// Latency: status outputs registered (1 cycle); capture_valid combinational; GPIO mirror +1 cycle.
// Backpressure: none; counters simply freeze on cycles with in_valid=0.
// Ports:   clk, reset (sync, active-high); bus = tag_rx_sched_if.slave (run_rx, in_valid,
//          peak_stb in; rx_state, rx_trig, rx_out_mux, capture_valid, loc_idx, sync_count,
//          timeout_err, fp_gpio_out, fp_gpio_ddr out).
module tag_rx_sched #(
    parameter int NSYNC_SKIP     = 32768,
    parameter int NSIG           = 262144,
    parameter int NLOC_PER_SYNC  = 3,
    parameter int TIMEOUT        = 1048576,
    parameter int REG_WIDTH      = 12,
    parameter int SYNC_CNT_WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    tag_rx_sched_if.slave    bus
);
    localparam int LOC_W = (NLOC_PER_SYNC > 1) ? $clog2(NLOC_PER_SYNC) : 1;
    // One sample counter serves both SKIP and CAPTURE, so size it for the longer phase.
    localparam int MAXC  = (NSYNC_SKIP > NSIG) ? NSYNC_SKIP : NSIG;
    localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int TMO_W = $clog2(TIMEOUT);

    localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'(NSYNC_SKIP - 1);
    localparam logic [CNT_W-1:0] SIG_LAST  = CNT_W'(NSIG - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [LOC_W-1:0] LOC_LAST  = LOC_W'(NLOC_PER_SYNC - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEARCH  = 2'd1,
        ST_SKIP    = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          samp_cnt_q, samp_cnt_d;
    logic [TMO_W-1:0]          tmo_cnt_q, tmo_cnt_d;
    logic [LOC_W-1:0]          loc_idx_q, loc_idx_d;
    logic [SYNC_CNT_WIDTH-1:0] sync_cnt_q, sync_cnt_d;
    logic                      rx_trig_q, rx_trig_d;
    logic                      rx_out_mux_q, rx_out_mux_d;
    logic                      timeout_err_q, timeout_err_d;
    logic [REG_WIDTH-1:0]      gpio_q, gpio_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            samp_cnt_q    <= '0;
            tmo_cnt_q     <= '0;
            loc_idx_q     <= '0;
            sync_cnt_q    <= '0;
            rx_trig_q     <= 1'b0;
            rx_out_mux_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            gpio_q        <= '0;
        end else begin
            state_q       <= state_d;
            samp_cnt_q    <= samp_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            loc_idx_q     <= loc_idx_d;
            sync_cnt_q    <= sync_cnt_d;
            rx_trig_q     <= rx_trig_d;
            rx_out_mux_q  <= rx_out_mux_d;
            timeout_err_q <= timeout_err_d;
            gpio_q        <= gpio_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        samp_cnt_d    = samp_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        loc_idx_d     = loc_idx_q;
        sync_cnt_d    = sync_cnt_q;
        rx_trig_d     = 1'b0;          // trigger and timeout are single-cycle pulses
        rx_out_mux_d  = rx_out_mux_q;
        timeout_err_d = 1'b0;

        if (state_q == ST_IDLE) begin
            if (bus.run_rx) begin
                state_d    = ST_SEARCH;
                samp_cnt_d = '0;
                tmo_cnt_d  = '0;
            end
        end else if (!bus.run_rx) begin
            // Abort: everything but the sync count goes back to rest; no trigger escapes.
            state_d      = ST_IDLE;
            samp_cnt_d   = '0;
            tmo_cnt_d    = '0;
            loc_idx_d    = '0;
            rx_out_mux_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_SEARCH: begin
                    // A peak beats a coincident timeout, and does not need in_valid.
                    if (bus.peak_stb) begin
                        state_d    = ST_SKIP;
                        sync_cnt_d = sync_cnt_q + SYNC_CNT_WIDTH'(1);
                        samp_cnt_d = '0;
                    end else if (bus.in_valid) begin
                        if (tmo_cnt_q == TMO_LAST) begin
                            timeout_err_d = 1'b1;
                            tmo_cnt_d     = '0;
                        end else begin
                            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                        end
                    end
                end
                ST_SKIP: begin
                    if (bus.in_valid) begin
                        if (samp_cnt_q == SKIP_LAST) begin
                            state_d      = ST_CAPTURE;
                            samp_cnt_d   = '0;
                            loc_idx_d    = '0;
                            rx_out_mux_d = 1'b1;
                            rx_trig_d    = 1'b1;
                        end else begin
                            samp_cnt_d = samp_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (bus.in_valid) begin
                        if (samp_cnt_q == SIG_LAST) begin
                            samp_cnt_d = '0;
                            if (loc_idx_q < LOC_LAST) begin
                                loc_idx_d = loc_idx_q + LOC_W'(1);
                                rx_trig_d = 1'b1;
                            end else begin
                                state_d      = ST_SEARCH;
                                loc_idx_d    = '0;
                                rx_out_mux_d = 1'b0;
                                tmo_cnt_d    = '0;
                            end
                        end else begin
                            samp_cnt_d = samp_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // GPIO mirrors the registered status, so it trails it by one cycle.
    always_comb begin
        gpio_d              = '0;
        gpio_d[1:0]         = state_q;
        gpio_d[2]           = rx_trig_q;
        gpio_d[3 +: LOC_W]  = loc_idx_q;
    end

    assign bus.rx_state      = state_q;
    assign bus.rx_trig       = rx_trig_q;
    assign bus.rx_out_mux    = rx_out_mux_q;
    assign bus.capture_valid = bus.in_valid && (state_q == ST_CAPTURE);
    assign bus.loc_idx       = loc_idx_q;
    assign bus.sync_count    = sync_cnt_q;
    assign bus.timeout_err   = timeout_err_q;
    assign bus.fp_gpio_out   = gpio_q;
    assign bus.fp_gpio_ddr   = '1;
endmodule
